// File: rtl/noc_flit_injector.sv
// Packet source for the NoC tree buffer write port.
// Emits head, payload and XOR-checksum tail flits under full backpressure.
module noc_flit_injector #(
    parameter int bit_width = 16,
    parameter int dest_w    = 4,
    parameter int len_w     = 4
) (
    input  logic                 clk_w,
    input  logic                 rst,
    input  logic                 req,
    input  logic [dest_w-1:0]    req_dest,
    input  logic [len_w-1:0]     req_len,
    input  logic [bit_width-1:0] pl_data,
    input  logic                 pl_valid,
    output logic                 pl_ready,
    input  logic                 full,
    output logic                 load,
    output logic [bit_width-1:0] flit,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY,
        TAIL
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [dest_w-1:0]    dest_r;
    logic [len_w-1:0]     len_r;
    logic [len_w-1:0]     cnt;
    logic [bit_width-1:0] csum;
    logic [bit_width-1:0] head_flit;

    // dest in the MSBs, len in the LSBs, zeros between
    always_comb begin
        head_flit = '0;
        head_flit[bit_width-1 -: dest_w] = dest_r;
        head_flit[len_w-1:0] = len_r;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        pl_ready = 1'b0;
        flit     = '0;
        unique case (state)
            IDLE: begin
                if (req) state_nx = HEAD;
            end
            HEAD: begin
                flit = head_flit;
                load = ~full;
                if (load) state_nx = (len_r != '0) ? BODY : TAIL;
            end
            BODY: begin
                flit     = pl_data;
                pl_ready = ~full;
                load     = pl_valid & ~full;
                if (load && cnt == len_w'(1)) state_nx = TAIL;
            end
            TAIL: begin
                flit = csum;
                load = ~full;
                if (load) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_w) begin
        if (rst) begin
            state   <= IDLE;
            dest_r  <= '0;
            len_r   <= '0;
            cnt     <= '0;
            csum    <= '0;
            done    <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        dest_r <= req_dest;
                        len_r  <= req_len;
                        cnt    <= req_len;
                        csum   <= '0;
                    end
                end
                BODY: begin
                    if (load) begin
                        csum <= csum ^ pl_data;
                        cnt  <= cnt - len_w'(1);
                    end
                end
                TAIL: begin
                    if (load) begin
                        done    <= 1'b1;
                        pkt_cnt <= pkt_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_noc_flit_injector.sv
// Randomized bench for noc_flit_injector against a packet-level model.
module tb_noc_flit_injector;

    localparam int BW = 16;
    localparam int DW = 4;
    localparam int LW = 4;

    logic          clk_w = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [DW-1:0] req_dest = '0;
    logic [LW-1:0] req_len = '0;
    logic [BW-1:0] pl_data = '0;
    logic          pl_valid = 1'b0;
    logic          pl_ready;
    logic          full = 1'b0;
    logic          load;
    logic [BW-1:0] flit;
    logic          busy;
    logic          done;
    logic [7:0]    pkt_cnt;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] pl_words[$];
    logic [BW-1:0] obs_q[$];
    logic [BW-1:0] exp_q[$];
    int            ready_cnt = 0;
    logic          prev_full = 1'b0;
    logic          prev_busy = 1'b0;
    logic [BW-1:0] prev_flit = '0;
    longint        t_done = 0;
    longint        gap_meas = 0;
    bit            gap_arm = 0;

    noc_flit_injector #(.bit_width(BW), .dest_w(DW), .len_w(LW)) dut (
        .clk_w(clk_w), .rst(rst), .req(req), .req_dest(req_dest),
        .req_len(req_len), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .full(full), .load(load), .flit(flit),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk_w = ~clk_w;

    // Observe the cycle's settled outputs; the accepting edge follows
    always @(negedge clk_w) begin
        if (!rst) begin
            if (load) obs_q.push_back(flit);
            if (pl_ready) ready_cnt++;
            if (load && gap_arm) begin
                gap_meas = $time - t_done;
                gap_arm = 0;
            end
            if (done) begin
                t_done = $time;
                gap_arm = 1;
            end
            if (full) begin
                checks++;
                if (load !== 1'b0) begin
                    errors++;
                    $display("FAIL load_under_full got %b want 0", load);
                end
            end
            if (prev_busy && prev_full && busy) begin
                checks++;
                if (flit !== prev_flit) begin
                    errors++;
                    $display("FAIL stall_flit got %h want %h", flit, prev_flit);
                end
            end
        end
        prev_full = full;
        prev_busy = busy;
        prev_flit = flit;
    end

    // Packet model: head, payload words, XOR of payload
    function automatic void build_exp(input logic [DW-1:0] dest, input logic [LW-1:0] len);
        logic [BW-1:0] x;
        exp_q.delete();
        exp_q.push_back(BW'((int'(dest) << (BW - DW)) | int'(len)));
        x = '0;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(pl_words[i]);
            x = x ^ pl_words[i];
        end
        exp_q.push_back(x);
    endfunction

    task automatic fill_words(input int n);
        pl_words.delete();
        for (int i = 0; i < n; i++) pl_words.push_back(BW'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk_w); #1;
        rst = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or right after a planted reset)
    task automatic send_pkt(input logic [DW-1:0] dest, input logic [LW-1:0] len,
                            input int head_stall, input int body_stall,
                            input int stall_at, input int vmode,
                            input bit rnd_full, input bit req_in_body,
                            input int rst_at, output int cyc, output bit tmo);
        int pi;
        int hs;
        int bs;
        bit took;
        pi = 0;
        hs = head_stall;
        bs = body_stall;
        cyc = 0;
        tmo = 0;
        req = 1'b1;
        req_dest = dest;
        req_len = len;
        full = 1'b0;
        pl_valid = 1'b0;
        @(posedge clk_w); #1;
        forever begin
            req = 1'b0;
            req_dest = DW'($urandom);
            req_len = LW'($urandom);
            if (req_in_body && pi > 0 && pi < int'(len)) req = 1'b1;
            if (hs > 0) begin
                full = 1'b1;
                hs--;
            end else if (pi == stall_at && bs > 0) begin
                full = 1'b1;
                bs--;
            end else begin
                full = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (pi < int'(len)) begin
                pl_data = pl_words[pi];
                case (vmode)
                    0: pl_valid = 1'b1;
                    1: pl_valid = (cyc % 2 == 0);
                    default: pl_valid = 1'($urandom_range(0, 1));
                endcase
            end else begin
                pl_data = BW'($urandom);
                pl_valid = 1'b1;
            end
            if (rst_at >= 0 && pi == rst_at) begin
                rst = 1'b1;
                full = 1'b0;
                @(posedge clk_w); #1;
                rst = 1'b0;
                return;
            end
            @(negedge clk_w);
            took = pl_valid && pl_ready;
            if (done) return;
            @(posedge clk_w); #1;
            if (took) pi++;
            cyc++;
            if (cyc > 400) begin
                tmo = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        pl_valid = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk_w);
        @(negedge clk_w);
        checks++;
        if ({load, pl_ready, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {load, pl_ready, busy, done});
        end
        checks++;
        if (pkt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt);
        end
        checks++;
        if (flit !== 16'h0000) begin
            errors++;
            $display("FAIL reset_flit got %h want 0000", flit);
        end
        @(posedge clk_w); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        bit tmo;
        obs_q.delete();
        pl_words = '{16'h1234, 16'h00FF};
        send_pkt(4'd3, 4'd2, 0, 0, -1, 0, 0, 0, -1, cyc, tmo);
        build_exp(4'd3, 4'd2);
        checks++;
        if (tmo || obs_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d want 4 tmo=%0d", obs_q.size(), tmo);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_flit%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (obs_q[0] !== 16'h3002 || obs_q[3] !== 16'h12CB) begin
                errors++;
                $display("FAIL basic_const got %h/%h want 3002/12cb", obs_q[0], obs_q[3]);
            end
        end
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL basic_cycles got %0d want 4", cyc);
        end
        checks++;
        if (pkt_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got cnt=%0d busy=%b want 1/0", pkt_cnt, busy);
        end
        @(negedge clk_w);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        bit tmo;
        obs_q.delete();
        pl_words.delete();
        ready_cnt = 0;
        send_pkt(4'hA, 4'd0, 0, 0, -1, 0, 0, 0, -1, cyc, tmo);
        checks++;
        if (tmo || obs_q.size() != 2) begin
            errors++;
            $display("FAIL zero_count got %0d want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 16'hA000 || obs_q[1] !== 16'h0000) begin
                errors++;
                $display("FAIL zero_flits got %h/%h want a000/0000", obs_q[0], obs_q[1]);
            end
        end
        checks++;
        if (ready_cnt != 0) begin
            errors++;
            $display("FAIL zero_pl_ready got %0d want 0", ready_cnt);
        end
        checks++;
        if (pkt_cnt !== 8'd2) begin
            errors++;
            $display("FAIL zero_pkt_cnt got %0d want 2", pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit tmo;
        logic [DW-1:0] d;
        obs_q.delete();
        fill_words(3);
        d = DW'($urandom);
        send_pkt(d, 4'd3, 3, 2, 1, 0, 0, 0, -1, cyc, tmo);
        build_exp(d, 4'd3);
        checks++;
        if (tmo || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_flit%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL bp_cycles got %0d want 10", cyc);
        end
    endtask

    task automatic test_bubbles();
        int cyc;
        bit tmo;
        obs_q.delete();
        pl_words = '{16'd1, 16'd2, 16'd3, 16'd4};
        send_pkt(4'd5, 4'd4, 0, 0, -1, 1, 0, 1, -1, cyc, tmo);
        build_exp(4'd5, 4'd4);
        checks++;
        if (tmo || obs_q.size() != 6) begin
            errors++;
            $display("FAIL bub_payloads got %0d want 4", obs_q.size() - 2);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bub_flit%0d got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (obs_q[5] !== 16'h0004) begin
                errors++;
                $display("FAIL bub_tail got %h want 0004", obs_q[5]);
            end
        end
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL bub_cycles got %0d want 10", cyc);
        end
        @(negedge clk_w);
        checks++;
        if (busy !== 1'b0 || pkt_cnt !== 8'd4) begin
            errors++;
            $display("FAIL bub_req_ignored got busy=%b cnt=%0d want 0/4", busy, pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit tmo;
        int bad;
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        logic [7:0] exp_cnt;
        do_reset();
        exp_cnt = 8'd0;
        bad = 0;
        for (int p = 0; p < 256; p++) begin
            obs_q.delete();
            d = DW'($urandom);
            l = LW'($urandom_range(0, 3));
            fill_words(int'(l));
            send_pkt(d, l, 0, 0, -1, (p < 2) ? 0 : 2, p >= 2, 0, -1, cyc, tmo);
            build_exp(d, l);
            exp_cnt = exp_cnt + 8'd1;
            checks++;
            if (tmo || obs_q != exp_q) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL b2b_pkt%0d got %0d flits want %0d", p, obs_q.size(), exp_q.size());
            end
            if (p == 1) begin
                checks++;
                if (gap_meas != 10) begin
                    errors++;
                    $display("FAIL b2b_gap got %0d want 10", gap_meas);
                end
            end
            if (p == 254) begin
                checks++;
                if (pkt_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL b2b_cnt255 got %0d want 255", pkt_cnt);
                end
            end
        end
        checks++;
        if (pkt_cnt !== exp_cnt || exp_cnt != 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap got %0d want 0", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit tmo;
        logic [DW-1:0] d;
        do_reset();
        obs_q.delete();
        fill_words(3);
        send_pkt(4'd7, 4'd3, 0, 0, -1, 0, 0, 0, 1, cyc, tmo);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_w);
            checks++;
            if (load !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 8'd0) begin
                errors++;
                $display("FAIL rst_mid_idle got load=%b busy=%b cnt=%0d want 0/0/0",
                         load, busy, pkt_cnt);
            end
        end
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL rst_mid_partial got %0d want 2", obs_q.size());
        end
        @(posedge clk_w); #1;
        obs_q.delete();
        fill_words(2);
        d = DW'($urandom);
        send_pkt(d, 4'd2, 0, 0, -1, 0, 0, 0, -1, cyc, tmo);
        build_exp(d, 4'd2);
        checks++;
        if (tmo || obs_q != exp_q) begin
            errors++;
            $display("FAIL rst_mid_restart got %0d flits tail %h want %h",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 16'h0,
                     exp_q[exp_q.size()-1]);
        end
        checks++;
        if (pkt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_mid_cnt got %0d want 1", pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_flit_injector.md
# noc_flit_injector

Write-side packet source for the NoC tree buffer. It turns a packet request (destination, length) plus a stream of payload words into a flit sequence: one head flit, N payload flits, and one XOR-checksum tail flit. It drives the buffer's `load`/data input under `full` backpressure. It sits between a local core/tile and the write port of the two-clock tree FIFO, and runs entirely in the buffer's `clk_w` domain.

## Interface
- `bit_width`, default 16: flit width; must equal the buffer's `bit_width`.
- `dest_w`, default 4: destination field width.
- `len_w`, default 4: payload-length field width; max payload is 2**len_w-1 flits. Constraint: `dest_w+len_w <= bit_width`.

- `clk_w` input 1: write clock, shared with buffer write port.
- `rst` input 1: reset, synchronous, active-high; clock `clk_w`.
- `req` input 1: start-packet request, sampled only in IDLE.
- `req_dest` input dest_w: destination, latched with `req`.
- `req_len` input len_w: payload flit count, latched with `req`; 0 is legal.
- `pl_data` input bit_width: payload word.
- `pl_valid` input 1: `pl_data` valid.
- `pl_ready` output 1: payload word taken this edge when `pl_valid & pl_ready`.
- `full` input 1: buffer full; no flit is accepted while high.
- `load` output 1: flit write strobe to the buffer.
- `flit` output bit_width: flit to the buffer `data_in`.
- `busy` output 1: packet in progress (state != IDLE).
- `done` output 1: one-cycle pulse after the tail flit is accepted.
- `pkt_cnt` output 8: packets completed, wraps 255→0.

## Operation
- State machine: IDLE, HEAD, BODY, TAIL. Registers: `dest_r`, `len_r`, `cnt` (len_w), `csum` (bit_width), `done`, `pkt_cnt`.
- Accept condition: a flit is accepted at a `clk_w` edge iff `load=1`. `load` is combinational and always includes `~full`.
- IDLE: `load=0`, `pl_ready=0`. If `req=1`, latch `req_dest→dest_r`, `req_len→len_r` and `cnt`, clear `csum`, then go to HEAD.
- HEAD:
  - `flit = {dest_r, zeros, len_r}`, with dest in the MSBs and len in the LSBs.
  - `load = ~full`.
  - On accept, go to BODY if `len_r != 0`, else go to TAIL.
- BODY:
  - `flit = pl_data`, `pl_ready = ~full`, `load = pl_valid & ~full`.
  - On accept: `csum ^= pl_data`, `cnt--`. Go to TAIL when `cnt` was 1.
  - A `pl_valid` gap inserts idle cycles with `load=0`.
- TAIL:
  - `flit = csum`, `load = ~full`.
  - On accept: go to IDLE, set `done=1` for the next cycle, increment `pkt_cnt`.
- `req` is ignored while `busy=1`.
- `req_dest`/`req_len` changes after the latch have no effect.
- `pl_ready` is 0 outside BODY. Payload words presented outside BODY are not consumed.
- When `load=0`, `flit` is don't-care for the buffer. Bench checks `flit` only when `load=1`.

## Timing
- Reset (at a `clk_w` edge with `rst=1`): state IDLE; `dest_r`, `len_r`, `cnt`, `csum` cleared; `done=0`; `pkt_cnt=0`. As a result `load=0`, `pl_ready=0`, `busy=0`, and `flit` is driven as 0.
- Reset mid-packet: abandon immediately, with no further `load`. The partial packet already in the buffer is not recalled. `pkt_cnt` is not incremented.
- `req` at edge k puts the block in HEAD during cycle k+1. The head flit is loaded at edge k+1 if `full=0`.
- With no stalls, a packet occupies `len+2` consecutive loading cycles. `done` is high in the first IDLE cycle.
- A `req` asserted in the `done` cycle is accepted, giving a 1-cycle gap between packets.
- `full` high stalls in place: state, `cnt` and `csum` are held and `flit` is held stable. Loading resumes in the cycle `full` drops, with no lost or duplicated flit.
- `full` and `pl_valid` may toggle every cycle. Only cycles with `~full & pl_valid` advance BODY.
- `cnt` never underflows: TAIL is entered exactly after `len_r` accepts. `len_r = 2**len_w-1` is legal.

## Test plan
- Basic packet: reset; `req` with dest=3, len=2; payload 0x1234, 0x00FF; `full=0`.
  - Loads exactly 0x3002, 0x1234, 0x00FF, 0x12CB on 4 consecutive edges.
  - `done` then pulses once and `pkt_cnt=1`.
- Zero-length packet: dest=0xA, len=0.
  - Loads 0xA000 then 0x0000.
  - `pl_ready` never asserts.
- Backpressure: len=3; `full` held high for 3 cycles at the HEAD flit and 2 cycles mid-BODY.
  - The flit sequence is identical to the unstalled run.
  - `load` is never high while `full=1`.
  - `flit` is stable throughout each stall.
- Payload bubbles: `pl_valid` alternating 1/0 with len=4, words 1,2,3,4.
  - Exactly 4 payload loads occur.
  - Tail flit is 0x0004.
  - `req` pulsed during BODY is ignored.
- Back-to-back: second `req` in the `done` cycle.
  - The second head loads 1 cycle after `done`.
  - 256 packets wrap `pkt_cnt` to 0.
- Reset mid-BODY: after 1 of 3 payloads, `rst` high for 1 edge.
  - `load=0` from that edge onward.
  - `busy=0`, `pkt_cnt` unchanged at 0.
  - A new `req` starts cleanly with a fresh checksum.
